// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a free-running binary up-counter and checks
// that each sample is exactly the previous sample + 1 (mod 2^WIDTH).
// Reports lock status, one-cycle wrap/error pulses and event tallies.
// Optional macro SEQCHK_STICKY_ERR_EN: when defined, ERROR is absorbing
// until clear; otherwise ERROR lasts one cycle and the block re-acquires.
module count_seq_checker #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             err_pulse,
  output logic [7:0]       wrap_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    ACQ,
    LOCKED,
    ERROR
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_THR = 4'(LOCK_LEN);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic [3:0]       good_run;
  logic [3:0]       good_run_nxt;
  logic             locked_nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic [7:0]       wrap_count_nxt;
  logic [7:0]       err_count_nxt;

  logic [WIDTH-1:0] expect_val;
  logic             match;
  logic [3:0]       run_inc;

  // Truncated sum, so CNT_MAX + 1 == 0 counts as a correct step.
  assign expect_val = prev + WIDTH'(1);
  assign match      = prev_valid && (cnt_in == expect_val);
  assign run_inc    = good_run + 4'd1;

  // Next-state and registered-output computation.
  always_comb begin
    state_nxt      = state;
    good_run_nxt   = good_run;
    locked_nxt     = locked;
    wrap_nxt       = 1'b0;
    err_nxt        = 1'b0;
    wrap_count_nxt = wrap_count;
    err_count_nxt  = err_count;

    case (state)
      ACQ: begin
        if (prev_valid) begin
          if (match) begin
            good_run_nxt = run_inc;
            if (run_inc == LOCK_THR) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end
          end else begin
            good_run_nxt = '0;
          end
        end
      end

      LOCKED: begin
        if (match) begin
          if (prev == CNT_MAX) begin
            wrap_nxt       = 1'b1;
            wrap_count_nxt = wrap_count + 8'd1;
          end
        end else begin
          err_nxt       = 1'b1;
          err_count_nxt = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
          state_nxt     = ERROR;
          locked_nxt    = 1'b0;
          good_run_nxt  = '0;
        end
      end

      ERROR: begin
`ifdef SEQCHK_STICKY_ERR_EN
        locked_nxt   = 1'b0;
        good_run_nxt = '0;
`else
        // The sample on the ERROR edge already counts towards re-acquisition.
        state_nxt    = ACQ;
        good_run_nxt = match ? 4'd1 : 4'd0;
        if (match && (LOCK_THR == 4'd1)) begin
          state_nxt  = LOCKED;
          locked_nxt = 1'b1;
        end
`endif
      end

      default: begin
        state_nxt    = ACQ;
        good_run_nxt = '0;
        locked_nxt   = 1'b0;
      end
    endcase
  end

  // State, history and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= ACQ;
      prev       <= '0;
      prev_valid <= 1'b0;
      good_run   <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      prev       <= cnt_in;
      prev_valid <= 1'b1;
      good_run   <= good_run_nxt;
      locked     <= locked_nxt;
      wrap_pulse <= wrap_nxt;
      err_pulse  <= err_nxt;
      wrap_count <= wrap_count_nxt;
      err_count  <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Testbench for count_seq_checker: behavioural reference model feeds a
// scoreboard queue at drive time; entries are popped after each edge.
// Follows SEQCHK_STICKY_ERR_EN the same way as the design.
module tb_count_seq_checker;

  localparam int unsigned W  = 3;
  localparam int unsigned LL = 4;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic [W-1:0] cnt_in = '0;
  logic         locked;
  logic         wrap_pulse;
  logic         err_pulse;
  logic [7:0]   wrap_count;
  logic [7:0]   err_count;

  count_seq_checker #(.WIDTH(W), .LOCK_LEN(LL)) dut (
    .clk(clk),
    .clear(clear),
    .cnt_in(cnt_in),
    .locked(locked),
    .wrap_pulse(wrap_pulse),
    .err_pulse(err_pulse),
    .wrap_count(wrap_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic       wp;
    logic       ep;
    logic [7:0] wc;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // reference model state
  logic [W-1:0] m_prev;
  logic         m_pv;
  int unsigned  m_run;
  int unsigned  m_st;   // 0 acquiring, 1 locked, 2 error
  logic         m_l, m_wp, m_ep;
  int unsigned  m_wc, m_ec;

  logic [W-1:0] cur;

  task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
    n_cmp++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_pv = 1'b0; m_run = 0; m_st = 0;
    m_l = 1'b0; m_wp = 1'b0; m_ep = 1'b0; m_wc = 0; m_ec = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] v);
    logic [W-1:0] nxt;
    logic ok;
    nxt = m_prev + 1'b1;
    ok  = m_pv && (v == nxt);
    m_wp = 1'b0;
    m_ep = 1'b0;
    if (m_st == 0) begin
      if (m_pv) begin
        m_run = ok ? m_run + 1 : 0;
        if (m_run == LL) begin m_st = 1; m_l = 1'b1; end
      end
    end else if (m_st == 1) begin
      if (!ok) begin
        m_ep = 1'b1;
        if (m_ec != 255) m_ec = m_ec + 1;
        m_st = 2; m_l = 1'b0; m_run = 0;
      end else if (v == '0) begin
        m_wp = 1'b1;
        m_wc = (m_wc + 1) % 256;
      end
    end else begin
`ifndef SEQCHK_STICKY_ERR_EN
      m_run = ok ? 1 : 0;
      m_st  = 0;
      if (m_run == LL) begin m_st = 1; m_l = 1'b1; end
`endif
    end
    m_prev = v;
    m_pv   = 1'b1;
  endtask

  // Entered at a falling edge; drives one sample, checks after the rising edge,
  // and returns at the next falling edge.
  task automatic step(input logic [W-1:0] v);
    exp_t e;
    exp_t g;
    cnt_in = v;
    model_edge(v);
    e.l = m_l; e.wp = m_wp; e.ep = m_ep; e.wc = 8'(m_wc); e.ec = 8'(m_ec);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("sb_locked", locked, g.l);
    check("sb_wrap_pulse", wrap_pulse, g.wp);
    check("sb_err_pulse", err_pulse, g.ep);
    check("sb_wrap_count", wrap_count, g.wc);
    check("sb_err_count", err_count, g.ec);
    check("sb_pulse_excl", wrap_pulse & err_pulse, 0);
    @(negedge clk);
  endtask

  task automatic adv();
    cur = cur + 1'b1;
    step(cur);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_locked"}, locked, 0);
    check({pfx, "_wrap_pulse"}, wrap_pulse, 0);
    check({pfx, "_err_pulse"}, err_pulse, 0);
    check({pfx, "_wrap_count"}, wrap_count, 0);
    check({pfx, "_err_count"}, err_count, 0);
  endtask

  // Clear for two cycles; returns at a falling edge with clear low.
  task automatic apply_clear();
    clear = 1'b1;
    #1;
    model_reset();
    sb.delete();
    check_zero("clr");
    repeat (2) @(negedge clk);
    clear = 1'b0;
  endtask

  // Clean start 0..4 -> locked on the fifth edge.
  task automatic lock_clean();
    cur = '0;
    step(cur);
    repeat (LL - 1) adv();
    check("lock_before", locked, 0);
    adv();
    check("lock_at_edge5", locked, 1);
  endtask

  initial begin
    int unsigned n;
    logic [W-1:0] v;
    logic [W-1:0] lastv;
    model_reset();
    @(negedge clk);

    // 1. reset and clean count with 20 wraps
    apply_clear();
    lock_clean();
    while (cur != 3'd7) adv();
    adv();
    check("first_wrap_pulse", wrap_pulse, 1);
    check("first_wrap_count", wrap_count, 1);
    repeat (19 * 8) adv();
    check("wraps20_count", wrap_count, 20);
    check("wraps20_err", err_count, 0);

    // 2. injected skip 3 -> 5 while locked
    while (cur != 3'd3) adv();
    cur = 3'd5;
    step(cur);
    check("skip_err_pulse", err_pulse, 1);
    check("skip_err_count", err_count, 1);
    check("skip_locked", locked, 0);
`ifdef SEQCHK_STICKY_ERR_EN
    repeat (50) adv();
    check("sticky_locked", locked, 0);
    check("sticky_err_count", err_count, 1);
`else
    repeat (LL - 1) adv();
    check("relock_pre", locked, 0);
    adv();
    check("relock_4edges", locked, 1);
`endif

    // 3. stall at 6 while locked
    apply_clear();
    lock_clean();
    while (cur != 3'd6) adv();
    step(cur);
    check("stall_err_pulse", err_pulse, 1);
    step(cur);
    check("stall_no_2nd", err_pulse, 0);
    repeat (8) adv();
    check("stall_err_count", err_count, 1);

    // 4. noise during acquisition, then clean run
    apply_clear();
    lastv = 3'($urandom_range(0, 7));
    step(lastv);
    for (int i = 0; i < 9; i++) begin
      v = 3'($urandom_range(0, 7));
      if (v == lastv + 3'd1) v = v + 3'd1;
      if (i == 8 && v == 3'd7) v = (lastv == 3'd0) ? 3'd2 : 3'd0;
      if (v == lastv + 3'd1) v = v + 3'd1;
      step(v);
      lastv = v;
    end
    check("noise_locked", locked, 0);
    check("noise_err_count", err_count, 0);
    lock_clean();

`ifndef SEQCHK_STICKY_ERR_EN
    // 5a. 300 errors with relock between -> saturate
    for (int i = 0; i < 300; i++) begin
      cur = cur + 3'd2;
      step(cur);
      repeat (LL) adv();
    end
    check("sat_err_count", err_count, 255);
    check("sat_locked", locked, 1);
`endif

    // 5b. 256 wraps -> wrap_count rolls to 0
    apply_clear();
    lock_clean();
    repeat (255 * 8) adv();
    check("roll_255", wrap_count, 255);
    repeat (8) adv();
    check("roll_0", wrap_count, 0);

    // 6. asynchronous clear mid-lock with wrap_count == 3
    apply_clear();
    lock_clean();
    repeat (3 * 8) adv();
    check("mid_wrap_count", wrap_count, 3);
    check("mid_locked", locked, 1);
    #2;
    clear = 1'b1;
    #1;
    check_zero("async");
    model_reset();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
    cur = '0;
    step(cur);
    n = 1;
    while (locked !== 1'b1 && n < 12) begin
      adv();
      n++;
    end
    check("relock_edges", n, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
